mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 70 +++++++
 rtl/mem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants for the memory access controller: size codes, FSM states, trap causes.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10,
        ST_TRAP   = 2'b11
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane steering: store replication/byte enables and load extraction/extension.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic [1:0]          size,
    input  logic                sign,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [ADDR_W-1:0]   lane_addr,
    output logic [DATA_W-1:0]   lane_wdata,
    output logic [DATA_W/8-1:0] lane_be,
    output logic [DATA_W-1:0]   lane_rdata
);

    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam logic [OW-1:0] LAST = OW'(NB - 1);

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v, input int nbytes,
                                                 input logic sgn);
        logic [DATA_W-1:0] r;
        logic              msb;
        msb = sgn & v[8*nbytes-1];
        for (int i = 0; i < DATA_W; i++)
            r[i] = (i < 8*nbytes) ? v[i] : msb;
        return r;
    endfunction

    logic [OW-1:0]     off;
    logic [OW-1:0]     sh;
    logic [DATA_W-1:0] lane;

    assign off       = addr[OW-1:0];
    assign lane_addr = {addr[ADDR_W-1:OW], OW'(0)};
    assign lane      = mem_rdata >> {sh, 3'b000};

    // sh is the lane index of the least-significant addressed byte; offset 0 is the top lane
    always_comb begin
        sh         = '0;
        lane_wdata = wdata;
        lane_be    = '1;
        lane_rdata = mem_rdata;
        case (size)
            SZ_BYTE: begin
                sh         = LAST - off;
                lane_wdata = {NB{wdata[7:0]}};
                lane_be    = NB'(1) << sh;
                lane_rdata = extend(lane, 1, sign);
            end
            SZ_HALF: begin
                sh         = LAST - OW'(1) - off;
                lane_wdata = {(NB/2){wdata[15:0]}};
                lane_be    = NB'(3) << sh;
                lane_rdata = extend(lane, 2, sign);
            end
            SZ_WORD: begin
                sh         = OW'(NB - 4) - off;
                lane_wdata = {(NB/4){wdata[31:0]}};
                lane_be    = NB'(15) << sh;
                lane_rdata = extend(lane, 4, sign);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller FSM (IDLE/ACCESS/DONE/TRAP) with alignment and size fault checks.
// Optional build macro MEM_TIMEOUT_EN adds an ACCESS wait counter that traps after TIMEOUT cycles.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                req,
    input  logic                rw,
    input  logic [1:0]          size,
    input  logic                sign,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                done,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic                mem_mov,
    output logic                mem_rw,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_moc
);

    function automatic logic [1:0] fault_of(input logic [1:0] sz, input logic [2:0] a);
        if (sz == SZ_DOUBLE && DATA_W == 32) return CAUSE_ILLEGAL;
        case (sz)
            SZ_HALF:   return a[0]        ? CAUSE_MISALIGN : CAUSE_NONE;
            SZ_WORD:   return |a[1:0]     ? CAUSE_MISALIGN : CAUSE_NONE;
            SZ_DOUBLE: return |a[2:0]     ? CAUSE_MISALIGN : CAUSE_NONE;
            default:   return CAUSE_NONE;
        endcase
    endfunction

    state_t              state;
    logic [1:0]          pend_cause;
    logic [1:0]          fault;
    logic                op_rw;
    logic [1:0]          op_size;
    logic                op_sign;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_wdata;
    logic [DATA_W/8-1:0] be_c;
    logic [DATA_W-1:0]   ext_rdata;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
`endif

    assign fault  = fault_of(size, addr[2:0]);
    assign mem_rw = op_rw;
    assign mem_be = mem_mov ? be_c : '0;

    mem_lane_align #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_align (
        .size       (op_size),
        .sign       (op_sign),
        .addr       (op_addr),
        .wdata      (op_wdata),
        .mem_rdata  (mem_rdata),
        .lane_addr  (mem_addr),
        .lane_wdata (mem_wdata),
        .lane_be    (be_c),
        .lane_rdata (ext_rdata)
    );

    // Operands only change in IDLE, which keeps the memory bus stable through ACCESS
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            op_rw    <= rw;
            op_size  <= size;
            op_sign  <= sign;
            op_addr  <= addr;
            op_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= ST_IDLE;
            mem_mov    <= 1'b0;
            done       <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
            rdata      <= '0;
            pend_cause <= CAUSE_NONE;
`ifdef MEM_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            done       <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (fault != CAUSE_NONE) begin
                            pend_cause <= fault;
                            state      <= ST_TRAP;
                        end else begin
                            mem_mov    <= 1'b1;
                            state      <= ST_ACCESS;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (mem_moc) begin
                        mem_mov <= 1'b0;
                        if (op_rw) rdata <= ext_rdata;
                        state   <= ST_DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        mem_mov    <= 1'b0;
                        pend_cause <= CAUSE_TIMEOUT;
                        state      <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_TRAP: begin
                    trap       <= 1'b1;
                    trap_cause <= pend_cause;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign = 1'b0;
    logic [31:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        mem_moc = 1'b0;
    logic [31:0] mrd_a = '0;
    logic [63:0] mrd_b = '0;

    logic [31:0] rdata_a, maddr_a, mwdata_a;
    logic        done_a, trap_a, mov_a, mrw_a;
    logic [1:0]  cause_a;
    logic [3:0]  be_a;

    logic [63:0] rdata_b, mwdata_b;
    logic [31:0] maddr_b;
    logic        done_b, trap_b, mov_b, mrw_b;
    logic [1:0]  cause_b;
    logic [7:0]  be_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut_a (
        .clk(clk), .clr(clr), .req(req_a), .rw(rw), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata[31:0]), .rdata(rdata_a), .done(done_a), .trap(trap_a),
        .trap_cause(cause_a), .mem_mov(mov_a), .mem_rw(mrw_a), .mem_addr(maddr_a),
        .mem_wdata(mwdata_a), .mem_be(be_a), .mem_rdata(mrd_a), .mem_moc(mem_moc)
    );

    mem_access_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) dut_b (
        .clk(clk), .clr(clr), .req(req_b), .rw(rw), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .rdata(rdata_b), .done(done_b), .trap(trap_b),
        .trap_cause(cause_b), .mem_mov(mov_b), .mem_rw(mrw_b), .mem_addr(maddr_b),
        .mem_wdata(mwdata_b), .mem_be(be_b), .mem_rdata(mrd_b), .mem_moc(mem_moc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic b, input logic r, input logic [1:0] s, input logic sg,
                         input logic [31:0] a, input logic [63:0] wd);
        rw = r; size = s; sign = sg; addr = a; wdata = wd;
        if (b) req_b = 1'b1; else req_a = 1'b1;
        tick();
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        check("rst_done", done_a, 1'b0);
        check("rst_trap", trap_a, 1'b0);
        check("rst_cause", cause_a, 2'b00);
        check("rst_rdata", rdata_a, 32'h0);
        check("rst_mov", mov_a, 1'b0);
        check("rst_be", be_a, 4'h0);
        @(negedge clk);
        clr = 1'b1;
        tick();

        // signed byte read, memory already complete
        mem_moc = 1'b1;
        mrd_a   = 32'h123456F0;
        issue(0, 1, 2'b00, 1, 32'h103, 64'h0);
        check("rb_mov_e1", mov_a, 1'b1);
        check("rb_done_e1", done_a, 1'b0);
        tick();
        check("rb_mov_e2", mov_a, 1'b0);
        check("rb_done_e2", done_a, 1'b0);
        tick();
        check("rb_done_e3", done_a, 1'b1);
        check("rb_rdata", rdata_a, 32'hFFFFFFF0);
        tick();
        check("rb_done_e4", done_a, 1'b0);
        check("rb_rdata_hold", rdata_a, 32'hFFFFFFF0);

        // half write with slow memory
        mem_moc = 1'b0;
        issue(0, 0, 2'b01, 0, 32'h202, 64'h0000BEEF);
        check("wh_mov", mov_a, 1'b1);
        check("wh_rw", mrw_a, 1'b0);
        check("wh_addr", maddr_a, 32'h200);
        check("wh_be", be_a, 4'b0011);
        check("wh_wdata", mwdata_a, 32'hBEEFBEEF);
        tick();
        tick();
        check("wh_mov_wait", mov_a, 1'b1);
        check("wh_be_wait", be_a, 4'b0011);
        mem_moc = 1'b1;
        tick();
        check("wh_mov_end", mov_a, 1'b0);
        check("wh_be_end", be_a, 4'b0000);
        tick();
        check("wh_done", done_a, 1'b1);
        check("wh_rdata_kept", rdata_a, 32'hFFFFFFF0);

        // byte write replication and lane enable
        issue(0, 0, 2'b00, 0, 32'h101, 64'h000000A5);
        check("wb_be", be_a, 4'b0100);
        check("wb_wdata", mwdata_a, 32'hA5A5A5A5);
        tick();
        tick();

        // zero-extended byte and sign-extended half reads
        mrd_a = 32'h80112233;
        issue(0, 1, 2'b00, 0, 32'h100, 64'h0);
        tick();
        tick();
        check("rbu_rdata", rdata_a, 32'h00000080);
        mrd_a = 32'h8001ABCD;
        issue(0, 1, 2'b01, 1, 32'h100, 64'h0);
        tick();
        tick();
        check("rhs_rdata", rdata_a, 32'hFFFF8001);
        mrd_a = 32'h1234ABCD;
        issue(0, 1, 2'b01, 0, 32'h102, 64'h0);
        tick();
        tick();
        check("rhu_rdata", rdata_a, 32'h0000ABCD);

        // misaligned word
        issue(0, 1, 2'b10, 0, 32'h006, 64'h0);
        check("mis_mov_e1", mov_a, 1'b0);
        tick();
        check("mis_trap", trap_a, 1'b1);
        check("mis_cause", cause_a, 2'b01);
        check("mis_mov_e2", mov_a, 1'b0);
        check("mis_done", done_a, 1'b0);
        tick();
        check("mis_trap_clr", trap_a, 1'b0);
        check("mis_cause_clr", cause_a, 2'b00);

        // illegal size has priority over misalignment
        issue(0, 1, 2'b11, 0, 32'h001, 64'h0);
        check("ill_mov", mov_a, 1'b0);
        tick();
        check("ill_trap", trap_a, 1'b1);
        check("ill_cause", cause_a, 2'b11);
        tick();

`ifdef MEM_TIMEOUT_EN
        // memory never answers
        mem_moc = 1'b0;
        issue(0, 1, 2'b10, 0, 32'h010, 64'h0);
        tick();
        tick();
        tick();
        check("to_mov_c4", mov_a, 1'b1);
        tick();
        check("to_mov_exp", mov_a, 1'b0);
        tick();
        check("to_trap", trap_a, 1'b1);
        check("to_cause", cause_a, 2'b10);
        check("to_done", done_a, 1'b0);
        tick();

        // completion on the expiry cycle wins
        mrd_a = 32'h5A5A0001;
        issue(0, 1, 2'b10, 0, 32'h010, 64'h0);
        tick();
        tick();
        tick();
        mem_moc = 1'b1;
        tick();
        check("tw_mov", mov_a, 1'b0);
        tick();
        check("tw_done", done_a, 1'b1);
        check("tw_trap", trap_a, 1'b0);
        check("tw_rdata", rdata_a, 32'h5A5A0001);
        tick();
`else
        // without the timeout the controller waits indefinitely
        mem_moc = 1'b0;
        issue(0, 1, 2'b10, 0, 32'h010, 64'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (trap_a) check("nt_trap", trap_a, 1'b0);
        end
        check("nt_mov", mov_a, 1'b1);
        mrd_a   = 32'h5A5A0001;
        mem_moc = 1'b1;
        tick();
        tick();
        check("nt_done", done_a, 1'b1);
        check("nt_rdata", rdata_a, 32'h5A5A0001);
        tick();
`endif

        // asynchronous reset mid-access
        mem_moc = 1'b0;
        issue(0, 0, 2'b10, 0, 32'h020, 64'h11223344);
        check("ar_mov_pre", mov_a, 1'b1);
        #2;
        clr = 1'b0;
        #1;
        check("ar_mov", mov_a, 1'b0);
        check("ar_be", be_a, 4'h0);
        check("ar_rdata", rdata_a, 32'h0);
        @(negedge clk);
        clr     = 1'b1;
        mem_moc = 1'b1;
        mrd_a   = 32'hCAFEBABE;
        #1;
        issue(0, 1, 2'b10, 0, 32'h104, 64'h0);
        check("ar2_mov", mov_a, 1'b1);
        tick();
        tick();
        check("ar2_done", done_a, 1'b1);
        check("ar2_rdata", rdata_a, 32'hCAFEBABE);
        tick();

        // 64-bit instance
        mrd_b = 64'h0123456789ABCDEF;
        issue(1, 1, 2'b11, 0, 32'h008, 64'h0);
        check("d_addr", maddr_b, 32'h8);
        check("d_be", be_b, 8'hFF);
        tick();
        tick();
        check("d_done", done_b, 1'b1);
        check("d_rdata", rdata_b, 64'h0123456789ABCDEF);
        check("d_trap", trap_b, 1'b0);
        tick();
        issue(1, 1, 2'b10, 1, 32'h00C, 64'h0);
        check("dw_be", be_b, 8'h0F);
        check("dw_addr", maddr_b, 32'h8);
        tick();
        tick();
        check("dw_rdata", rdata_b, 64'hFFFFFFFF89ABCDEF);
        issue(1, 1, 2'b00, 0, 32'h009, 64'h0);
        tick();
        tick();
        check("db_rdata", rdata_b, 64'h23);
        issue(1, 0, 2'b01, 0, 32'h00A, 64'h0000BEEF);
        check("dh_be", be_b, 8'b0011_0000);
        check("dh_wdata", mwdata_b, 64'hBEEFBEEFBEEFBEEF);
        tick();
        tick();
        issue(1, 1, 2'b11, 0, 32'h004, 64'h0);
        tick();
        check("dmis_trap", trap_b, 1'b1);
        check("dmis_cause", cause_b, 2'b01);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
